// File: rtl/shift_seq_pkg.sv
// Shared definitions for the sequenced shifter: op encodings and FSM state type.
package shift_seq_pkg;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_seq_if.sv
// Request/response handshake bundle between the operand logic and the shifter.
interface shift_seq_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [CNT_W-1:0] in_cnt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_data, in_cnt, in_op, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_cnt, in_op, out_ready,
    output in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/shift_stage.sv
// Fixed-amount single shift stage; the sequencer picks one of these per cycle.
module shift_stage
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SH    = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       op_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    unique case (op_i)
      OP_ROL: data_o = {data_i[WIDTH-1-SH:0], data_i[WIDTH-1:WIDTH-SH]};
      OP_SLL: data_o = {data_i[WIDTH-1-SH:0], {SH{1'b0}}};
      // Sign bit is invariant under SRA, so chained stages equal one big shift.
      OP_SRA: data_o = {{SH{data_i[WIDTH-1]}}, data_i[WIDTH-1:SH]};
      OP_SRL: data_o = {{SH{1'b0}}, data_i[WIDTH-1:SH]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Iterative 16-bit shifter: applies one power-of-two stage per cycle, highest bit first.
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  shift_seq_if.slave  bus
);

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] rem_q;
  logic [1:0]       op_q;

  logic [WIDTH-1:0] stage_out [CNT_W];
  logic [CNT_W-1:0] hi_oh;
  logic [CNT_W-1:0] rem_clr;
  logic [WIDTH-1:0] shifted;

  for (genvar g = 0; g < CNT_W; g++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .SH    (1 << g)
    ) u_stage (
      .data_i (data_q),
      .op_i   (op_q),
      .data_o (stage_out[g])
    );
  end

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    hi_oh   = '0;
    shifted = '0;
    for (int i = 0; i < CNT_W; i++) begin
      if (rem_q[i]) begin
        hi_oh    = '0;
        hi_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < CNT_W; i++) begin
      if (hi_oh[i]) shifted = shifted | stage_out[i];
    end
    rem_clr = rem_q & ~hi_oh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      rem_q   <= '0;
      op_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            data_q  <= bus.in_data;
            rem_q   <= bus.in_cnt;
            op_q    <= bus.in_op;
            state_q <= (bus.in_cnt == '0) ? StDone : StShift;
          end
        end
        StShift: begin
          data_q <= shifted;
          rem_q  <= rem_clr;
          if (rem_clr == '0) state_q <= StDone;
        end
        StDone: begin
          if (bus.out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_data  = (state_q == StDone) ? data_q : '0;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed table, async-reset corners, random vs model.
module tb_shift_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  shift_seq_if #(.WIDTH(16), .CNT_W(4)) bus ();

  shift_seq #(
    .WIDTH (16),
    .CNT_W (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  cnt;
    logic [1:0]  op;
    logic [15:0] exp;
    int          lat;
    int          hold;
    bit          scramble;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: whole shift by the full count in one go.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input int c,
                                            input logic [1:0] op);
    logic [31:0] w;
    case (op)
      2'b00: begin
        w = {d, d} << c;
        return w[31:16];
      end
      2'b01:   return d << c;
      2'b10:   return 16'($signed(d) >>> c);
      default: return d >> c;
    endcase
  endfunction

  task automatic run_req(input logic [15:0] d, input logic [3:0] c, input logic [1:0] op,
                         input logic [15:0] exp, input int lat, input int hold,
                         input bit scramble);
    int n;
    @(negedge clk);
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_cnt    = c;
    bus.in_op     = op;
    bus.out_ready = 1'b0;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    while (!bus.out_valid && n < 10) begin
      check("busy_shift", bus.busy, 1);
      check("in_ready_shift", bus.in_ready, 0);
      check("out_data_zero", bus.out_data, 0);
      if (scramble) begin
        bus.in_valid  = 1'($urandom);
        bus.in_data   = 16'($urandom);
        bus.in_cnt    = 4'($urandom);
        bus.in_op     = 2'($urandom);
        bus.out_ready = 1'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency", n, lat);
    check("result", bus.out_data, exp);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'($urandom);
      bus.in_cnt    = 4'($urandom);
      bus.out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", bus.out_data, exp);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_busy", bus.busy, 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post_in_ready", bus.in_ready, 1);
    check("post_out_valid", bus.out_valid, 0);
    check("post_out_data", bus.out_data, 0);
    check("post_busy", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    n_checks = 0;
    n_errors = 0;

    vecs[0] = '{16'h0001, 4'd5,  2'b01, 16'h0020, 3, 1, 1'b0};
    vecs[1] = '{16'h8001, 4'd1,  2'b00, 16'h0003, 2, 1, 1'b0};
    vecs[2] = '{16'h1234, 4'd8,  2'b00, 16'h3412, 2, 1, 1'b0};
    vecs[3] = '{16'h8000, 4'd15, 2'b10, 16'hFFFF, 5, 1, 1'b0};
    vecs[4] = '{16'h8000, 4'd15, 2'b11, 16'h0001, 5, 1, 1'b0};
    vecs[5] = '{16'h4000, 4'd2,  2'b10, 16'h1000, 2, 1, 1'b0};
    vecs[6] = '{16'h1234, 4'd0,  2'b00, 16'h1234, 1, 3, 1'b0};
    vecs[7] = '{16'h00FF, 4'd4,  2'b01, 16'h0FF0, 2, 1, 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_cnt    = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    #12;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_req(vecs[i].data, vecs[i].cnt, vecs[i].op, vecs[i].exp, vecs[i].lat,
              vecs[i].hold, vecs[i].scramble);
    end

    // Asynchronous reset while shifting.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h00FF;
    bus.in_cnt   = 4'd15;
    bus.in_op    = 2'b01;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("mid_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_shift_in_ready", bus.in_ready, 1);
    check("arst_shift_out_valid", bus.out_valid, 0);
    check("arst_shift_out_data", bus.out_data, 0);
    check("arst_shift_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset while a result is waiting.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hABCD;
    bus.in_cnt   = 4'd0;
    bus.in_op    = 2'b11;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("done_out_valid", bus.out_valid, 1);
    check("done_out_data", bus.out_data, 16'hABCD);
    #2 rst_n = 1'b0;
    #1;
    check("arst_done_out_valid", bus.out_valid, 0);
    check("arst_done_out_data", bus.out_data, 0);
    check("arst_done_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    run_req(16'hC3A5, 4'd6, 2'b10, ref_shift(16'hC3A5, 6, 2'b10), 3, 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] d;
      logic [3:0]  c;
      logic [1:0]  op;
      d  = 16'($urandom);
      c  = 4'($urandom_range(0, 15));
      op = 2'($urandom_range(0, 3));
      run_req(d, c, op, ref_shift(d, int'(c), op), 1 + $countones(c),
              $urandom_range(0, 2), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
